// File: rtl/reg_pkg.sv
// Shared defaults for the datapath storage registers.
// Width and reset value used as the parameter defaults of reg_32.
package reg_pkg;

  localparam int          REG_WIDTH       = 32;
  localparam logic [31:0] REG_RESET_VALUE = 32'h0000_0000;

endpackage

// File: rtl/reg_bit_en.sv
// One storage bit: synchronous active-high reset, load enable.
// The enable is a D-input mux, so the clock is never gated.
module reg_bit_en #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  output logic q
);

  // Reset wins over load; otherwise capture when enabled, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_32.sv
// Load-enabled storage register built from WIDTH enable flops.
// storedData comes straight from the flops; no input pass-through.
module reg_32
  import reg_pkg::*;
#(
  parameter int               WIDTH       = REG_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inputData,
  input  logic             loadEnable,
  output logic [WIDTH-1:0] storedData
);

  // Each bit takes its own slice of the reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    reg_bit_en #(
      .RST_VAL (RESET_VALUE[i])
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .d   (inputData[i]),
      .en  (loadEnable),
      .q   (storedData[i])
    );
  end

endmodule

// File: tb/tb_reg_32.sv
// Directed bench for reg_32: load, hold, reset priority.
// Inputs change 1 ns after posedge; output sampled 1 ns after posedge.
`timescale 1ns/1ps
module tb_reg_32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inputData = '0;
  logic        loadEnable = 1'b0;
  logic [31:0] storedData;

  int checks = 0;
  int errors = 0;

  reg_32 dut (
    .clk        (clk),
    .rst        (rst),
    .inputData  (inputData),
    .loadEnable (loadEnable),
    .storedData (storedData)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, check 1 ns later.
  task automatic step(input logic r,
                      input logic e,
                      input logic [31:0] d,
                      input logic [31:0] exp,
                      input string tag);
    rst        = r;
    loadEnable = e;
    inputData  = d;
    @(posedge clk);
    #1;
    chk(tag, storedData, exp);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset state
    step(1'b1, 1'b0, 32'h1234_5678, 32'h0, "reset");
    // initial load of zero
    step(1'b0, 1'b1, 32'h0, 32'h0, "init_load");
    // hold with changing data
    step(1'b0, 1'b0, 32'h1, 32'h0, "hold_1");
    step(1'b0, 1'b0, 32'h2, 32'h0, "hold_2");
    step(1'b0, 1'b0, 32'h4, 32'h0, "hold_4");
    // load tracking
    step(1'b0, 1'b1, 32'h1, 32'h1, "load_1");
    step(1'b0, 1'b1, 32'h2, 32'h2, "load_2");
    step(1'b0, 1'b1, 32'h4, 32'h4, "load_4");
    // reset beats load
    step(1'b1, 1'b1, 32'h4, 32'h0, "rst_over_load");
    step(1'b0, 1'b1, 32'h4, 32'h4, "reload_4");
    // hold after load
    step(1'b0, 1'b0, 32'h1, 32'h4, "hold_a");
    step(1'b0, 1'b0, 32'h1, 32'h4, "hold_b");
    // full-width patterns
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "load_ones");
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "load_dead");
    step(1'b0, 1'b1, 32'h5A5A_A5A5, 32'h5A5A_A5A5, "load_5a");
    step(1'b0, 1'b0, 32'h0000_0000, 32'h5A5A_A5A5, "hold_5a");
    // mid-cycle changes must not reach the output
    rst        = 1'b1;
    loadEnable = 1'b1;
    inputData  = 32'h0F0F_0F0F;
    #40;
    chk("no_async", storedData, 32'h5A5A_A5A5);
    rst = 1'b0;
    #5;
    chk("no_pass", storedData, 32'h5A5A_A5A5);
    @(posedge clk);
    #1;
    chk("load_0f", storedData, 32'h0F0F_0F0F);
    // corner: reset with all-ones data
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, "rst_ones");
    step(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, "hold_after_rst");
    step(1'b0, 1'b0, 32'h8000_0001, 32'h0, "hold_after_rst2");
    // reset with load low also clears
    step(1'b0, 1'b1, 32'h8000_0001, 32'h8000_0001, "load_edges");
    step(1'b1, 1'b0, 32'h7777_7777, 32'h0, "rst_no_load");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
